// File: rtl/regfile_sb_pkg.sv
// Shared types and limits for the scoreboarded register file.
package regfile_sb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rfsb_state_t;

  localparam int unsigned RFSB_MAX_RD = 4;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per stored register and the issue handshake.
// r0 has no busy bit; the exported vector ties bit 0 low.
module regfile_sb_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             ready_i,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic             iss_en_i,
  input  logic [AW-1:0]    iss_addr_i,
  output logic             iss_ok_o,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:1] busy_q, busy_d;

  assign busy_o = {busy_q, 1'b0};

  // A retire landing on the same register in the same cycle frees the slot for the new issue.
  assign iss_ok_o = ready_i && (!busy_o[iss_addr_i] || (we_i && (wa_i == iss_addr_i)));

  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (ready_i && we_i && (wa_i == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
      // Issue is applied after retire so it wins on a same-register collision.
      if (iss_en_i && iss_ok_o && (iss_addr_i == AW'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-write scoreboard and a post-reset clear sweep.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  output logic                 ready_o,
  input  logic [NRD*AW-1:0]    rd_addr_i,
  output logic [NRD*WIDTH-1:0] rd_data_o,
  output logic [NRD-1:0]       rd_busy_o,
  input  logic                 we_i,
  input  logic [AW-1:0]        wa_i,
  input  logic [WIDTH-1:0]     wd_i,
  input  logic                 iss_en_i,
  input  logic [AW-1:0]        iss_addr_i,
  output logic                 iss_ok_o
);

  if ((NRD < 1) || (NRD > RFSB_MAX_RD)) begin : g_bad_nrd
    $error("regfile_sb: NRD must be in 1..%0d", RFSB_MAX_RD);
  end
  if ((NREGS < 4) || ((NREGS & (NREGS - 1)) != 0)) begin : g_bad_nregs
    $error("regfile_sb: NREGS must be a power of 2 and at least 4");
  end

  rfsb_state_t      state_q;
  logic [AW-1:0]    clr_ptr_q;
  logic [WIDTH-1:0] rf_q [NREGS-1:1];
  logic [NREGS-1:0] busy;

  assign ready_o = (state_q == ST_RUN);

  // Sweep walks r1..r(NREGS-1); the pointer wraps to 0 as it leaves the sweep.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= AW'(1);
    end else if (state_q == ST_CLEAR) begin
      clr_ptr_q <= clr_ptr_q + AW'(1);
      if (clr_ptr_q == AW'(NREGS - 1)) begin
        state_q <= ST_RUN;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (state_q == ST_CLEAR) begin
        rf_q[clr_ptr_q] <= '0;
      end else if (we_i && (wa_i != '0)) begin
        rf_q[wa_i] <= wd_i;
      end
    end
  end

  regfile_sb_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .ready_i    (ready_o),
    .we_i       (we_i),
    .wa_i       (wa_i),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .iss_ok_o   (iss_ok_o),
    .busy_o     (busy)
  );

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (ready_o && (rd_addr_i[i*AW +: AW] != '0)) begin
        rd_data_o[i*WIDTH +: WIDTH] = rf_q[rd_addr_i[i*AW +: AW]];
        rd_busy_o[i]                = busy[rd_addr_i[i*AW +: AW]];
`ifdef REGFILE_SB_BYPASS_EN
        if (we_i && (wa_i == rd_addr_i[i*AW +: AW])) begin
          rd_data_o[i*WIDTH +: WIDTH] = wd_i;
          rd_busy_o[i]                = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised self-checking bench for regfile_sb against a behavioural register-file model.
// A second small instance (NRD=4, NREGS=16, WIDTH=16) checks the parameterised build.
module tb_regfile_sb;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int N4 = 16;

  logic        clk = 1'b0;
  logic        reset, ready, we, iss_en, iss_ok;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [4:0]  wa, iss_addr;
  logic [31:0] wd;

  logic        reset4, ready4, we4, iss_ok4;
  logic [15:0] rd_addr4;
  logic [63:0] rd_data4;
  logic [3:0]  rd_busy4, wa4;
  logic [15:0] wd4;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_rf   [N];
  bit          m_busy [N];
  int          m_cnt  = 0;

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .ready_o    (ready),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .we_i       (we),
    .wa_i       (wa),
    .wd_i       (wd),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .iss_ok_o   (iss_ok)
  );

  regfile_sb #(
    .WIDTH (16),
    .NREGS (N4),
    .NRD   (4)
  ) u_dut4 (
    .clk_i      (clk),
    .reset_i    (reset4),
    .ready_o    (ready4),
    .rd_addr_i  (rd_addr4),
    .rd_data_o  (rd_data4),
    .rd_busy_o  (rd_busy4),
    .we_i       (we4),
    .wa_i       (wa4),
    .wd_i       (wd4),
    .iss_en_i   (1'b0),
    .iss_addr_i (4'd0),
    .iss_ok_o   (iss_ok4)
  );

  function automatic bit m_ready();
    return m_cnt >= N - 1;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (!m_ready() || a == 0) return 32'd0;
`ifdef REGFILE_SB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_rf[a];
  endfunction

  function automatic bit m_rdbusy(input logic [4:0] a);
    if (!m_ready() || a == 0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
    if (we && wa == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic bit m_iss_ok();
    return m_ready() && (!m_busy[iss_addr] || (we && wa == iss_addr));
  endfunction

  // Advance the model by one clock using the inputs currently driven, then step the clock.
  task automatic tick();
    bit ok;
    ok = m_iss_ok();
    if (reset) begin
      m_cnt = 0;
      for (int a = 0; a < N; a++) begin
        m_rf[a]   = '0;
        m_busy[a] = 1'b0;
      end
    end else if (!m_ready()) begin
      m_cnt++;
    end else begin
      if (we && wa != 0) begin
        m_rf[wa]   = wd;
        m_busy[wa] = 1'b0;
      end
      if (iss_en && ok && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset  = 1'b0;
    we     = 1'b0;
    iss_en = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < N - 1; c++) begin
      we       = 1'($urandom);
      wa       = 5'($urandom);
      wd       = $urandom;
      iss_en   = 1'b1;
      iss_addr = 5'($urandom);
      rd_addr  = 10'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({ready, rd_busy, iss_ok, rd_data} !== '0) begin
        n_fail++;
        $display("FAIL sweep_quiet c=%0d: ready=%b busy=%b iss_ok=%b data=%h, required all 0",
                 c, ready, rd_busy, iss_ok, rd_data);
      end
      tick();
    end
    idle();
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_rise: ready=%b, required 1 after %0d cycles", ready, N - 1);
    end
    for (int a = 0; a < N; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      @(negedge clk);
      n_cmp++;
      if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL cleared r%0d/r%0d: data=%h busy=%b, required 0", a, a + 1, rd_data, rd_busy);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int c;
    idle();
    we = 1'b1;
    wa = 5'd12;
    wd = 32'hA5A5_0001;
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    c = 0;
    while (c < 64) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      c++;
      tick();
    end
    n_cmp++;
    if (c != N - 1) begin
      n_fail++;
      $display("FAIL mid_sweep_reset: ready after %0d cycles, required %0d", c, N - 1);
    end
    rd_addr = {5'd0, 5'd12};
    @(negedge clk);
    n_cmp++;
    if (rd_data[31:0] !== 32'd0) begin
      n_fail++;
      $display("FAIL resweep_r12: data=%h, required 0", rd_data[31:0]);
    end
    tick();
  endtask

  task automatic test_write_read();
    idle();
    we      = 1'b1;
    wa      = 5'd5;
    wd      = 32'hDEAD_BEEF;
    rd_addr = {5'd0, 5'd5};
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF || rd_data[63:32] !== 32'd0) begin
      n_fail++;
      $display("FAIL write_read_r5: data=%h, required 00000000deadbeef", rd_data);
    end
    we      = 1'b1;
    wa      = 5'd0;
    wd      = 32'hFFFF_FFFF;
    rd_addr = {5'd5, 5'd0};
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rd_data !== 64'hDEAD_BEEF_0000_0000) begin
      n_fail++;
      $display("FAIL r0_write_dropped: data=%h, required deadbeef00000000", rd_data);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    rd_addr  = {5'd7, 5'd7};
    iss_en   = 1'b1;
    iss_addr = 5'd7;
    @(negedge clk);
    n_cmp++;
    if (iss_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_r7_first: iss_ok=%b, required 1", iss_ok);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (rd_busy !== 2'b11 || iss_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL issue_r7_again: busy=%b iss_ok=%b, required 11/0", rd_busy, iss_ok);
    end
    tick();
    iss_en = 1'b0;
    we     = 1'b1;
    wa     = 5'd7;
    wd     = $urandom;
    tick();
    idle();
    iss_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rd_busy !== 2'b00 || iss_ok !== 1'b1 || rd_data[31:0] !== m_rf[7]) begin
      n_fail++;
      $display("FAIL retire_r7: busy=%b iss_ok=%b data=%h, required 00/1/%h",
               rd_busy, iss_ok, rd_data[31:0], m_rf[7]);
    end
    tick();
    idle();
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    idle();
    iss_en   = 1'b1;
    iss_addr = 5'd9;
    tick();
    v        = $urandom;
    we       = 1'b1;
    wa       = 5'd9;
    wd       = v;
    rd_addr  = {5'd0, 5'd9};
    @(negedge clk);
    n_cmp++;
    if (iss_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_iss_ok: iss_ok=%b, required 1", iss_ok);
    end
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rd_data[31:0] !== v || rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_r9: data=%h busy=%b, required %h/1", rd_data[31:0], rd_busy[0], v);
    end
    we = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_bypass();
    logic [31:0] old;
    idle();
    iss_en   = 1'b1;
    iss_addr = 5'd3;
    tick();
    idle();
    old     = m_rf[3];
    we      = 1'b1;
    wa      = 5'd3;
    wd      = 32'h1234_5678;
    rd_addr = {5'd3, 5'd0};
    @(negedge clk);
    n_cmp++;
`ifdef REGFILE_SB_BYPASS_EN
    if (rd_data[63:32] !== 32'h1234_5678 || rd_busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_r3: data=%h busy=%b, required 12345678/0", rd_data[63:32], rd_busy[1]);
    end
`else
    if (rd_data[63:32] !== old || rd_busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL no_bypass_r3: data=%h busy=%b, required %h/1", rd_data[63:32], rd_busy[1], old);
    end
`endif
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rd_data[63:32] !== 32'h1234_5678 || rd_busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL after_write_r3: data=%h busy=%b, required 12345678/0",
               rd_data[63:32], rd_busy[1]);
    end
    tick();
  endtask

  task automatic test_random();
    logic [63:0] exp_d;
    logic [1:0]  exp_b;
    bit          exp_ok;
    for (int c = 0; c < 600; c++) begin
      reset    = ($urandom_range(0, 249) == 0);
      we       = 1'($urandom);
      wa       = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wd       = $urandom;
      iss_en   = 1'($urandom);
      iss_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      rd_addr  = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
      exp_d    = {m_rd(rd_addr[9:5]), m_rd(rd_addr[4:0])};
      exp_b    = {m_rdbusy(rd_addr[9:5]), m_rdbusy(rd_addr[4:0])};
      exp_ok   = m_iss_ok();
      @(negedge clk);
      n_cmp++;
      if (rd_data !== exp_d || rd_busy !== exp_b || iss_ok !== exp_ok || ready !== m_ready()) begin
        n_fail++;
        $display("FAIL random c=%0d: data=%h busy=%b iss_ok=%b ready=%b, required %h/%b/%b/%b",
                 c, rd_data, rd_busy, iss_ok, ready, exp_d, exp_b, exp_ok, m_ready());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_ports4();
    int c;
    logic [15:0] vals [4];
    logic [3:0]  addrs [4];
    logic [63:0] exp_d;
    addrs  = '{4'd2, 4'd5, 4'd11, 4'd15};
    we4    = 1'b0;
    reset4 = 1'b1;
    tick();
    reset4 = 1'b0;
    c = 0;
    while (c < 64) begin
      @(negedge clk);
      if (ready4 === 1'b1) break;
      c++;
      tick();
    end
    n_cmp++;
    if (c != N4 - 1) begin
      n_fail++;
      $display("FAIL nrd4_ready: ready after %0d cycles, required %0d", c, N4 - 1);
    end
    for (int i = 0; i < 4; i++) begin
      vals[i] = 16'($urandom);
      we4     = 1'b1;
      wa4     = addrs[i];
      wd4     = vals[i];
      tick();
    end
    we4      = 1'b0;
    rd_addr4 = {addrs[3], addrs[2], addrs[1], addrs[0]};
    exp_d    = {vals[3], vals[2], vals[1], vals[0]};
    @(negedge clk);
    n_cmp++;
    if (rd_data4 !== exp_d || rd_busy4 !== 4'b0000 || iss_ok4 !== 1'b1) begin
      n_fail++;
      $display("FAIL nrd4_read: data=%h busy=%b iss_ok=%b, required %h/0000/1",
               rd_data4, rd_busy4, iss_ok4, exp_d);
    end
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    we       = 1'b0;
    wa       = '0;
    wd       = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
    rd_addr  = '0;
    reset4   = 1'b1;
    we4      = 1'b0;
    wa4      = '0;
    wd4      = '0;
    rd_addr4 = '0;
    #1;
    test_reset();
    test_reset_mid();
    test_write_read();
    test_scoreboard();
    test_simultaneous();
    test_bypass();
    test_random();
    test_ports4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
